riscv_apb_arbiter: RTL and testbench

//  Two-master to one-slave APB arbiter downstream of the core's imem and dmem APB master ports.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/riscv_arb_pick.sv | 34 +++
 rtl/riscv_apb_arbiter.sv | 115 +++++++++++
 tb/tb_riscv_apb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// The round-robin option is selected by RISCV_APB_ARB_RR_EN (see riscv_arb_pick).
package riscv_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS} apb_arb_state_t;

    localparam logic ARB_M_IMEM = 1'b0;
    localparam logic ARB_M_DMEM = 1'b1;

endpackage

// File: rtl/riscv_arb_pick.sv
// Combinational winner selection between imem (m0) and dmem (m1) requests.
// Define RISCV_APB_ARB_RR_EN for round-robin; otherwise dmem has fixed priority.
module riscv_arb_pick
    import riscv_pkg::*;
(
    input  logic m1_psel,
    input  logic m0_psel,
    input  logic last_grant,
    output logic grant
);

`ifdef RISCV_APB_ARB_RR_EN
    // On a tie the master that was not served last wins.
    always_comb begin
        grant = ARB_M_IMEM;
        if (m1_psel && m0_psel) begin
            grant = ~last_grant;
        end else if (m1_psel) begin
            grant = ARB_M_DMEM;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = ARB_M_IMEM;
        if (m1_psel) begin
            grant = ARB_M_DMEM;
        end
    end
`endif

endmodule

// File: rtl/riscv_apb_arbiter.sv
// Two-master to one-slave APB arbiter: re-issues each granted request as SETUP->ACCESS.
// Define RISCV_APB_ARB_RR_EN to build the last-grant register and round-robin arbitration.
module riscv_apb_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_psel_i,
    input  logic              m0_penable_i,
    input  logic [ADDR_W-1:0] m0_paddr_i,
    input  logic              m0_pwrite_i,
    input  logic [DATA_W-1:0] m0_pwdata_i,
    output logic              m0_pready_o,
    output logic [DATA_W-1:0] m0_prdata_o,
    input  logic              m1_psel_i,
    input  logic              m1_penable_i,
    input  logic [ADDR_W-1:0] m1_paddr_i,
    input  logic              m1_pwrite_i,
    input  logic [DATA_W-1:0] m1_pwdata_i,
    output logic              m1_pready_o,
    output logic [DATA_W-1:0] m1_prdata_o,
    output logic              s_psel_o,
    output logic              s_penable_o,
    output logic [ADDR_W-1:0] s_paddr_o,
    output logic              s_pwrite_o,
    output logic [DATA_W-1:0] s_pwdata_o,
    input  logic              s_pready_i,
    input  logic [DATA_W-1:0] s_prdata_i
);

    apb_arb_state_t    state;
    logic              grant;
    logic              pick;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done;

    // Grant follows psel alone; master penable carries no information here.
    logic unused_penable;
    assign unused_penable = m0_penable_i ^ m1_penable_i;

    // Reset in the completing cycle abandons the transfer, so no pready escapes.
    assign done = (state == ARB_ACCESS) && s_pready_i && !reset;

`ifdef RISCV_APB_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= ARB_M_DMEM;
        end else if (done) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = ARB_M_DMEM;
`endif

    riscv_arb_pick u_pick (
        .m1_psel    (m1_psel_i),
        .m0_psel    (m0_psel_i),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB_IDLE;
            grant   <= ARB_M_IMEM;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (m0_psel_i || m1_psel_i) begin
                        grant <= pick;
                        state <= ARB_SETUP;
                        if (pick == ARB_M_DMEM) begin
                            addr_q  <= m1_paddr_i;
                            write_q <= m1_pwrite_i;
                            wdata_q <= m1_pwdata_i;
                        end else begin
                            addr_q  <= m0_paddr_i;
                            write_q <= m0_pwrite_i;
                            wdata_q <= m0_pwdata_i;
                        end
                    end
                end
                ARB_SETUP: state <= ARB_ACCESS;
                ARB_ACCESS: begin
                    if (s_pready_i) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign s_psel_o    = (state != ARB_IDLE);
    assign s_penable_o = (state == ARB_ACCESS);
    assign s_paddr_o   = addr_q;
    assign s_pwrite_o  = write_q;
    assign s_pwdata_o  = wdata_q;

    assign m0_pready_o = done && (grant == ARB_M_IMEM);
    assign m1_pready_o = done && (grant == ARB_M_DMEM);
    assign m0_prdata_o = m0_pready_o ? s_prdata_i : '0;
    assign m1_prdata_o = m1_pready_o ? s_prdata_i : '0;

endmodule

// File: tb/tb_riscv_apb_arbiter.sv
// Randomised scoreboard bench for riscv_apb_arbiter; honours RISCV_APB_ARB_RR_EN in its model.
module tb_riscv_apb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int unsigned GEN_END = 3000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_psel_i = 1'b0, m0_penable_i = 1'b0, m0_pwrite_i = 1'b0;
    logic [AW-1:0] m0_paddr_i = '0;
    logic [DW-1:0] m0_pwdata_i = '0;
    logic          m0_pready_o;
    logic [DW-1:0] m0_prdata_o;
    logic          m1_psel_i = 1'b0, m1_penable_i = 1'b0, m1_pwrite_i = 1'b0;
    logic [AW-1:0] m1_paddr_i = '0;
    logic [DW-1:0] m1_pwdata_i = '0;
    logic          m1_pready_o;
    logic [DW-1:0] m1_prdata_o;
    logic          s_psel_o, s_penable_o, s_pwrite_o;
    logic [AW-1:0] s_paddr_o;
    logic [DW-1:0] s_pwdata_o;
    logic          s_pready_i = 1'b0;
    logic [DW-1:0] s_prdata_i = '0;

    riscv_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_psel_i(m0_psel_i), .m0_penable_i(m0_penable_i), .m0_paddr_i(m0_paddr_i),
        .m0_pwrite_i(m0_pwrite_i), .m0_pwdata_i(m0_pwdata_i),
        .m0_pready_o(m0_pready_o), .m0_prdata_o(m0_prdata_o),
        .m1_psel_i(m1_psel_i), .m1_penable_i(m1_penable_i), .m1_paddr_i(m1_paddr_i),
        .m1_pwrite_i(m1_pwrite_i), .m1_pwdata_i(m1_pwdata_i),
        .m1_pready_o(m1_pready_o), .m1_prdata_o(m1_prdata_o),
        .s_psel_o(s_psel_o), .s_penable_o(s_penable_o), .s_paddr_o(s_paddr_o),
        .s_pwrite_o(s_pwrite_o), .s_pwdata_o(s_pwdata_o),
        .s_pready_i(s_pready_i), .s_prdata_i(s_prdata_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          m;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned t_grant;
        int unsigned t_done;
    } xfer_t;

    xfer_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned reset_cyc = 1;
    bit          stop_mon = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, req);
        end
    endtask

    // Transaction-level model: each master holds one pending request until served;
    // the bus carries one transfer at a time with a known number of slave wait states.
    bit          pend[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    bit          p_wr[2];
    bit          busy = 0;
    bit          last_srv = 1;
    xfer_t       cur;
    int unsigned n_xfer = 0;
    int unsigned n_rst = 0;

    task automatic drive_masters();
        logic [31:0] a[2];
        logic [31:0] d[2];
        bit          w[2];
        for (int i = 0; i < 2; i++) begin
            if (busy && cur.m == i[0] && cyc > cur.t_grant) begin
                a[i] = $urandom; d[i] = $urandom; w[i] = $urandom_range(0, 1);
            end else begin
                a[i] = p_addr[i]; d[i] = p_wdata[i]; w[i] = p_wr[i];
            end
        end
        m0_psel_i = pend[0]; m0_paddr_i = a[0]; m0_pwdata_i = d[0]; m0_pwrite_i = w[0];
        m1_psel_i = pend[1]; m1_paddr_i = a[1]; m1_pwdata_i = d[1]; m1_pwrite_i = w[1];
        m0_penable_i = $urandom_range(0, 1);
        m1_penable_i = $urandom_range(0, 1);
    endtask

    initial begin
        int unsigned waits;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; p_wr[i] = 0;
        end
        while (cyc < GEN_END || busy || pend[0] || pend[1]) begin
            @(negedge clk);
            if (cyc > GEN_END + 400) begin
                check("drain_timeout", 1, 0);
                break;
            end
            if (cyc < 2) begin
                reset = 1'b1;
                continue;
            end
            reset = 1'b0;
            if (busy && cyc > cur.t_done) begin
                pend[cur.m] = 0;
                busy = 0;
            end
            if (busy && cyc > 20 && cyc >= cur.t_grant + 2 && cyc <= cur.t_done &&
                n_rst < 4 && $urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                reset_cyc = cyc;
                n_rst++;
                busy = 0;
                last_srv = 1;
                exp_q.delete(exp_q.size() - 1);
                drive_masters();
                s_pready_i = 1'b1;
                s_prdata_i = $urandom;
                continue;
            end
            if (cyc == 2) begin
                pend[0] = 1; p_addr[0] = 32'h0000_0010; p_wr[0] = 0; p_wdata[0] = '0;
            end
            if (cyc == 5) begin
                pend[1] = 1; p_addr[1] = 32'h0000_0100; p_wr[1] = 1; p_wdata[1] = 32'hDEAD_BEEF;
            end
            if (cyc >= 11 && cyc < GEN_END) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1;
                        p_addr[i] = $urandom & 32'hFFFF_FFFC;
                        p_wr[i] = $urandom_range(0, 1);
                        p_wdata[i] = $urandom;
                    end
                end
            end
            if (!busy && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef RISCV_APB_ARB_RR_EN
                    cur.m = ~last_srv;
`else
                    cur.m = 1;
`endif
                end else begin
                    cur.m = pend[1];
                end
                last_srv = cur.m;
                waits = (n_xfer == 0) ? 0 : (n_xfer == 1) ? 3 : $urandom_range(0, 3);
                cur.addr = p_addr[cur.m];
                cur.wr = p_wr[cur.m];
                cur.wdata = p_wdata[cur.m];
                cur.rdata = (n_xfer == 0) ? 32'h0051_3093 : $urandom;
                cur.t_grant = cyc;
                cur.t_done = cyc + 2 + waits;
                exp_q.push_back(cur);
                busy = 1;
                n_xfer++;
            end
            drive_masters();
            if (busy && cyc == cur.t_done) begin
                s_pready_i = 1'b1;
                s_prdata_i = cur.rdata;
            end else if (busy && cyc >= cur.t_grant + 2) begin
                s_pready_i = 1'b0;
                s_prdata_i = $urandom;
            end else begin
                s_pready_i = $urandom_range(0, 1);
                s_prdata_i = $urandom;
            end
        end
        @(negedge clk);
        m0_psel_i = 0; m1_psel_i = 0; s_pready_i = 0;
        repeat (3) @(negedge clk);
        stop_mon = 1;
        #3;
        check("drain", 128'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        bit    act;
        bit    fin;
        xfer_t h;
        forever begin
            @(negedge clk);
            #2;
            if (stop_mon) break;
            if (cyc < 1) continue;
            if (cyc == reset_cyc) begin
                check("rst_resp", {m0_pready_o, m1_pready_o, m0_prdata_o, m1_prdata_o}, 0);
            end else if (cyc == reset_cyc + 1) begin
                check("rst_zero", {m0_pready_o, m1_pready_o, m0_prdata_o, m1_prdata_o,
                                   s_psel_o, s_penable_o, s_paddr_o, s_pwrite_o, s_pwdata_o}, 0);
            end else begin
                act = 0;
                h = '{default: 0};
                if (exp_q.size() > 0 && cyc > exp_q[0].t_grant) begin
                    act = 1;
                    h = exp_q[0];
                end
                check("bus_ctl", {s_psel_o, s_penable_o}, {act, act && cyc >= h.t_grant + 2});
                if (act)
                    check("bus_xfer", {s_paddr_o, s_pwrite_o, s_pwdata_o}, {h.addr, h.wr, h.wdata});
                fin = act && cyc == h.t_done;
                check("m0_resp", {m0_pready_o, m0_prdata_o},
                      (fin && !h.m) ? {1'b1, h.rdata} : 33'd0);
                check("m1_resp", {m1_pready_o, m1_prdata_o},
                      (fin && h.m) ? {1'b1, h.rdata} : 33'd0);
                if (fin) void'(exp_q.pop_front());
            end
        end
    end

endmodule
